// File: rtl/shared_memory_banked.sv
// Banked shared-memory scratchpad serving a warp of lanes per request; bank conflicts are replayed in passes.
// Optional SHARED_MEM_BROADCAST_EN: same-address read lanes are served together in one pass.
module shared_memory_banked #(
    parameter int NUM_THREADS   = 8,
    parameter int NUM_BANKS     = 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       req_valid,
    output logic                                       req_ready,
    input  logic                                       write_en,
    input  logic [NUM_THREADS-1:0]                     thread_mask,
    input  logic [NUM_THREADS-1:0][ADDRESS_WIDTH-1:0]  addr,
    input  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]     write_data,
    output logic                                       resp_valid,
    output logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]     read_data,
    output logic                                       bank_conflict,
    output logic [$clog2(NUM_THREADS):0]               conflict_passes,
    output logic [1:0]                                 debug_state
);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int ROW_BITS  = ADDRESS_WIDTH - BANK_BITS;
    localparam int DEPTH     = 2 ** ROW_BITS;
    localparam int PASS_W    = $clog2(NUM_THREADS) + 1;

    typedef enum logic [1:0] {IDLE, SERVE, DRAIN, RESP} state_t;

    state_t state, state_next;

    logic                                       we_q;
    logic [NUM_THREADS-1:0]                     pending_q, pending_next;
    logic [NUM_THREADS-1:0][ADDRESS_WIDTH-1:0]  addr_q;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]     wdata_q;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]     result_q;
    logic [NUM_THREADS-1:0]                     grant, grant_q;
    logic [PASS_W-1:0]                          passes_q;

    logic [NUM_BANKS-1:0]                       bank_en, bank_we;
    logic [NUM_BANKS-1:0][ROW_BITS-1:0]         bank_row;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]       bank_wdata;
    logic [DATA_WIDTH-1:0]                      bank_rdata [NUM_BANKS];
`ifdef SHARED_MEM_BROADCAST_EN
    logic [NUM_BANKS-1:0][ADDRESS_WIDTH-1:0]    sel_addr;
`endif

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and the requester holds the request until then.
    assign req_ready       = (state == IDLE);
    assign resp_valid      = (state == RESP);
    assign read_data       = result_q;
    assign conflict_passes = passes_q;
    assign bank_conflict   = (passes_q > PASS_W'(1));
    assign debug_state     = state;

    // Per-bank arbitration: the lowest-index pending lane mapping to a bank wins this pass.
    always_comb begin
        grant      = '0;
        bank_en    = '0;
        bank_row   = '0;
        bank_wdata = '0;
`ifdef SHARED_MEM_BROADCAST_EN
        sel_addr   = '0;
`endif
        if (state == SERVE) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int t = 0; t < NUM_THREADS; t++) begin
                    if (pending_q[t] && !bank_en[b] &&
                        addr_q[t][BANK_BITS-1:0] == BANK_BITS'(b)) begin
                        bank_en[b]    = 1'b1;
                        grant[t]      = 1'b1;
                        bank_row[b]   = addr_q[t][ADDRESS_WIDTH-1:BANK_BITS];
                        bank_wdata[b] = wdata_q[t];
`ifdef SHARED_MEM_BROADCAST_EN
                        sel_addr[b]   = addr_q[t];
`endif
                    end
                end
`ifdef SHARED_MEM_BROADCAST_EN
                if (!we_q && bank_en[b]) begin
                    for (int t = 0; t < NUM_THREADS; t++) begin
                        if (pending_q[t] && addr_q[t] == sel_addr[b])
                            grant[t] = 1'b1;
                    end
                end
`endif
            end
        end
        bank_we      = bank_en & {NUM_BANKS{we_q}};
        pending_next = pending_q & ~grant;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = SERVE;
            SERVE:   if (pending_next == '0) state_next = DRAIN;
            DRAIN:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            pending_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            result_q  <= '0;
            grant_q   <= '0;
            passes_q  <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q      <= write_en;
                    pending_q <= thread_mask;
                    addr_q    <= addr;
                    wdata_q   <= write_data;
                    result_q  <= '0;
                    grant_q   <= '0;
                    passes_q  <= '0;
                end
                SERVE: begin
                    pending_q <= pending_next;
                    grant_q   <= grant;
                    passes_q  <= passes_q + PASS_W'(1);
                end
                DRAIN:   grant_q <= '0;
                default: ;
            endcase
            // Bank outputs lag the grant by one cycle, so capture uses the registered grant.
            if ((state == SERVE || state == DRAIN) && !we_q) begin
                for (int t = 0; t < NUM_THREADS; t++) begin
                    if (grant_q[t])
                        result_q[t] <= bank_rdata[addr_q[t][BANK_BITS-1:0]];
                end
            end
        end
    end

    // Storage is deliberately unreset so contents survive rst_n.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (bank_en[b]) begin
                if (bank_we[b]) mem[bank_row[b]] <= bank_wdata[b];
                else            bank_rdata[b]    <= mem[bank_row[b]];
            end
        end
    end
endmodule

// File: tb/tb_shared_memory_banked.sv
// Directed bench for shared_memory_banked: latency, pass counts, conflicts, masking, broadcast, reset abort.
module tb_shared_memory_banked;
    localparam int NT = 8;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int PW = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   req_valid = 1'b0;
    logic                   req_ready;
    logic                   write_en = 1'b0;
    logic [NT-1:0]          thread_mask = '0;
    logic [NT-1:0][AW-1:0]  addr = '0;
    logic [NT-1:0][DW-1:0]  write_data = '0;
    logic                   resp_valid;
    logic [NT-1:0][DW-1:0]  read_data;
    logic                   bank_conflict;
    logic [PW-1:0]          conflict_passes;
    logic [1:0]             debug_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_q[$];

    logic [NT-1:0][AW-1:0]  va;
    logic [NT-1:0][DW-1:0]  vd;
    logic [NT-1:0][DW-1:0]  vexp;
    int                     bcast_p;

    shared_memory_banked #(
        .NUM_THREADS(NT), .NUM_BANKS(8), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .write_en(write_en), .thread_mask(thread_mask), .addr(addr),
        .write_data(write_data), .resp_valid(resp_valid), .read_data(read_data),
        .bank_conflict(bank_conflict), .conflict_passes(conflict_passes),
        .debug_state(debug_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one request, then checks latency, pass count, conflict flag and per-lane data.
    task automatic run_req(input string tag, input logic we, input logic [NT-1:0] mask,
                           input logic [NT-1:0][AW-1:0] a, input logic [NT-1:0][DW-1:0] d,
                           input logic [NT-1:0][DW-1:0] exp_rd, input int exp_p);
        int  cyc;
        bit  seen;
        for (int i = 0; i < NT; i++) exp_q.push_back(exp_rd[i]);
        @(negedge clk);
        check({tag, ".ready_in"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; write_en = we; thread_mask = mask; addr = a; write_data = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        write_data = '1;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({tag, ".busy"}, 32'(req_ready), 32'd0);
            if (resp_valid) seen = 1'b1;
        end
        check({tag, ".latency"}, 32'(cyc), 32'(exp_p + 2));
        check({tag, ".passes"}, 32'(conflict_passes), 32'(exp_p));
        check({tag, ".conflict"}, 32'(bank_conflict), 32'(exp_p > 1));
        for (int i = 0; i < NT; i++)
            check($sformatf("%s.lane%0d", tag, i), 32'(read_data[i]), 32'(exp_q.pop_front()));
        @(negedge clk);
        check({tag, ".ready_out"}, 32'(req_ready), 32'd1);
        check({tag, ".pulse"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int  cnt;
        bit  seen;
`ifdef SHARED_MEM_BROADCAST_EN
        bcast_p = 1;
`else
        bcast_p = 8;
`endif
        repeat (3) @(negedge clk);
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.resp", 32'(resp_valid), 32'd0);
        check("rst.data", 32'(read_data != '0), 32'd0);
        check("rst.conflict", 32'(bank_conflict), 32'd0);
        check("rst.passes", 32'(conflict_passes), 32'd0);
        check("rst.state", 32'(debug_state), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NT; i++) begin va[i] = AW'(i); vd[i] = DW'(16'h1000 + i); end
        run_req("wr_free", 1'b1, 8'hFF, va, vd, '0, 1);
        run_req("rd_free", 1'b0, 8'hFF, va, '0, vd, 1);

        for (int i = 0; i < NT; i++) begin va[i] = AW'(8 * i); vd[i] = DW'(16'h2000 + i); end
        run_req("wr_conf", 1'b1, 8'hFF, va, vd, '0, 8);
        run_req("rd_conf", 1'b0, 8'hFF, va, '0, vd, 8);

        for (int i = 0; i < NT; i++) begin va[i] = 8'h05; vd[i] = DW'(i + 1); end
        run_req("wr_same", 1'b1, 8'h0F, va, vd, '0, 4);
        vexp = '0; vexp[0] = 16'd4;
        run_req("rd_same", 1'b0, 8'h01, va, '0, vexp, 1);

        va = '0; va[0] = 8'h21; vd = '0; vd[0] = 16'hABCD;
        run_req("wr_bc", 1'b1, 8'h01, va, vd, '0, 1);
        for (int i = 0; i < NT; i++) begin va[i] = 8'h21; vexp[i] = 16'hABCD; end
        run_req("rd_bc", 1'b0, 8'hFF, va, '0, vexp, bcast_p);

        va = '0; va[2] = 8'h0B; vd = '0; vd[2] = 16'hB0B0;
        run_req("wr_0b", 1'b1, 8'h04, va, vd, '0, 1);
        for (int i = 0; i < NT; i++) va[i] = AW'(i);
        va[0] = 8'h03; va[1] = 8'h03; va[2] = 8'h0B;
        vexp = '0; vexp[0] = 16'h1003; vexp[2] = 16'hB0B0;
        run_req("rd_mask", 1'b0, 8'b0000_0101, va, '0, vexp, 2);
        run_req("rd_zero", 1'b0, 8'h00, va, '0, '0, 1);

        for (int i = 0; i < NT; i++) va[i] = AW'(8 * i);
        @(negedge clk);
        req_valid = 1'b1; write_en = 1'b0; thread_mask = 8'hFF; addr = va;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.ready", 32'(req_ready), 32'd1);
        check("abort.resp", 32'(resp_valid), 32'd0);
        check("abort.passes", 32'(conflict_passes), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (cnt = 0; cnt < 15; cnt++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check("abort.no_resp", 32'(seen), 32'd0);

        for (int i = 0; i < NT; i++) begin va[i] = AW'(i); vexp[i] = DW'(16'h1000 + i); end
        vexp[0] = 16'h2000;
        vexp[5] = 16'h0004;
        run_req("rd_after", 1'b0, 8'hFF, va, '0, vexp, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/shared_memory_banked.md
Name: shared_memory_banked

Overview:
- Parametrised banked shared-memory scratchpad for one compute unit, serving a warp of NUM_THREADS lanes per request.
- Address low bits select the bank and upper bits select the row.
- Bank conflicts are detected and serialised in hardware as multi-pass replay, instead of only being flagged.
- A single request/response handshake lets the lane datapath stall while the block is busy.

Parameters:
- NUM_THREADS, 8, lanes per request.
- NUM_BANKS, 8, power of two; bank = addr[$clog2(NUM_BANKS)-1:0].
- ADDRESS_WIDTH, 8, word address width; bank depth = 2**(ADDRESS_WIDTH-$clog2(NUM_BANKS)).
- DATA_WIDTH, 16, word width.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block is idle and accepts a request.
- write_en  in  1  1 = write request, 0 = read request, for all lanes.
- thread_mask  in  NUM_THREADS  per-lane active bit.
- addr  in  ADDRESS_WIDTH x NUM_THREADS  per-lane word address.
- write_data  in  DATA_WIDTH x NUM_THREADS  per-lane write data.
- resp_valid  out  1  one-cycle pulse; read_data and stats are valid.
- read_data  out  DATA_WIDTH x NUM_THREADS  per-lane read result.
- bank_conflict  out  1  the completed request needed more than one pass.
- conflict_passes  out  $clog2(NUM_THREADS)+1  number of passes P used by the completed request.

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous, active-low.
- Reset values:
  - state = IDLE, req_ready = 1, resp_valid = 0.
  - read_data all 0, bank_conflict = 0, conflict_passes = 0.
  - Pending mask cleared.
  - Bank arrays are not reset; their contents are preserved across reset.
- FSM has four states: IDLE, SERVE, DRAIN, RESP. req_ready = (state == IDLE).
- IDLE:
  - On req_valid && req_ready, latch write_en, mask, addr and write_data.
  - Set pending = thread_mask, clear result registers to 0, go to SERVE.
- SERVE (one cycle per pass):
  - For each bank, grant the lowest-index pending lane that maps to it.
  - Drive that bank's enable, row, we and wdata, then clear the granted pending bits.
  - Increment the pass counter. Register the grant vector for capture on the next cycle.
  - Leave SERVE when the post-grant pending mask is 0.
  - An all-zero mask still spends exactly one SERVE cycle, with no bank enables and P = 1.
- Banks: synchronous single-port, one-cycle read latency, write-first not required. A write pass returns no data.
- DRAIN: capture the final pass's read data into the granted lanes' result registers, then go to RESP.
  - Capture also happens each SERVE cycle for the previous pass.
- RESP:
  - resp_valid = 1 for exactly one cycle.
  - read_data = results: 0 for inactive lanes and on writes.
  - conflict_passes = P, bank_conflict = (P > 1).
  - Next state IDLE. Outputs other than resp_valid hold until the next acceptance.
- Latency: acceptance at edge 0, resp_valid high in cycle P+2, req_ready high again in cycle P+3.
- P equals the maximum number of active lanes sharing one bank (this is modified under the optional feature).
- Same-address writes by multiple lanes: lowest index writes first, so the highest-index lane's data persists.
- Same-address reads without the optional feature serialise like any conflict.
- req_valid while busy is ignored. The requester must hold the request until req_ready.
- Reset asserted mid-request: the request is aborted, no resp_valid is generated, and any partial writes already committed remain.

Optional Feature:
- Macro: SHARED_MEM_BROADCAST_EN.
- Defined:
  - On read requests, every pending lane whose full address equals the granted lane's address is served in the same pass and captures the same bank output.
  - P becomes the maximum number of distinct addresses per bank.
  - Writes are unchanged and serialise by lane index.
- Undefined: strictly one lane per bank per pass. No address-comparator logic is synthesised.

Test Plan:
- Conflict-free: write lane i addr i data 16'h1000+i (mask 8'hFF), then read the same addresses -> each response has P = 1, bank_conflict = 0, resp_valid in cycle 3, read_data[i] = 16'h1000+i.
- Full conflict: read mask 8'hFF with addr[i] = 8*i (all bank 0) -> P = 8, bank_conflict = 1, resp_valid in cycle 10, each lane gets its own word.
- Same-address write: lanes 0..3 write addr 8'h05 with data 1, 2, 3, 4 -> P = 4; a following read of 8'h05 returns 4.
- Broadcast: all 8 lanes read addr 8'h21 -> with SHARED_MEM_BROADCAST_EN, P = 1 and resp in cycle 3; without it, P = 8. All lanes return the same word.
- Masking: mask 8'b0000_0101 with lanes 0 and 2 both in bank 3 -> P = 2; lanes 1 and 3..7 read 0. Mask 8'h00 -> P = 1, resp in cycle 3, no bank access.
- Reset mid-request: assert rst_n = 0 during SERVE of an 8-pass read -> resp_valid never pulses, req_ready = 1 immediately, next request completes normally.
